// File: rtl/decode_issue_reg.sv
// Decode-to-execute pipeline register: operand select with forwarding, stall/flush
// handling, valid/ready launch into execute, and a saturating hazard-stall counter.
module decode_issue_reg #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_D,
  output logic              ready_D,
  input  logic [31:0]       pc_D,
  input  logic [31:0]       imm_D,
  input  logic [4:0]        type_D,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic [4:0]        rd_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic              stall_D,
  input  logic [31:0]       forward_rs1,
  input  logic [31:0]       forward_rs2,
  input  logic              valid_forward_rs1,
  input  logic              valid_forward_rs2,
  input  logic              flush,
  output logic              valid_E,
  input  logic              ready_E,
  output logic [31:0]       pc_E,
  output logic [31:0]       imm_E,
  output logic [4:0]        type_E,
  output logic [4:0]        rd_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [31:0]       src1_E,
  output logic [31:0]       src2_E,
  output logic [31:0]       stall_cnt
);

  localparam int DATA_W = 32;

  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [4:0]        idx,
    input logic              use_fwd,
    input logic [DATA_W-1:0] fwd,
    input logic [DATA_W-1:0] rf
  );
    if (idx == 5'd0) return '0;
    return use_fwd ? fwd : rf;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic              fire_p0;
  logic              stall_evt_p0;

  // Decode side: operand select and handshake
  always_comb begin
    op1_p0       = sel_operand(rs1_D, valid_forward_rs1, forward_rs1, rf_rdata1);
    op2_p0       = sel_operand(rs2_D, valid_forward_rs2, forward_rs2, rf_rdata2);
    ready_D      = (~valid_E | ready_E) & ~stall_D & ~flush;
    fire_p0      = valid_D & ready_D;
    stall_evt_p0 = valid_D & stall_D & ~flush;
  end

  // Execute side: the registered instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_E <= 1'b0;
      pc_E    <= '0;
      imm_E   <= '0;
      type_E  <= '0;
      rd_E    <= '0;
      ctrl_E  <= '0;
      src1_E  <= '0;
      src2_E  <= '0;
    end else if (flush) begin
      valid_E <= 1'b0;
      rd_E    <= '0;
    end else if (fire_p0) begin
      valid_E <= 1'b1;
      pc_E    <= pc_D;
      imm_E   <= imm_D;
      type_E  <= type_D;
      rd_E    <= rd_D;
      ctrl_E  <= ctrl_D;
      src1_E  <= op1_p0;
      src2_E  <= op2_p0;
    end else if (valid_E & ready_E) begin
      // Bubble: clear rd so the hazard unit never matches a departed instruction
      valid_E <= 1'b0;
      rd_E    <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_evt_p0) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_decode_issue_reg.sv
// Bench for decode_issue_reg: directed scenarios followed by random traffic,
// all compared against an execute-slot reference model.
module tb_decode_issue_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_D, ready_D;
  logic [31:0] pc_D, imm_D;
  logic [4:0]  type_D, rs1_D, rs2_D, rd_D;
  logic [15:0] ctrl_D;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        stall_D;
  logic [31:0] forward_rs1, forward_rs2;
  logic        valid_forward_rs1, valid_forward_rs2;
  logic        flush;
  logic        valid_E, ready_E;
  logic [31:0] pc_E, imm_E;
  logic [4:0]  type_E, rd_E;
  logic [15:0] ctrl_E;
  logic [31:0] src1_E, src2_E, stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_issue_reg #(.CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .ready_D(ready_D),
    .pc_D(pc_D), .imm_D(imm_D), .type_D(type_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rd_D(rd_D), .ctrl_D(ctrl_D), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .stall_D(stall_D), .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .valid_forward_rs1(valid_forward_rs1), .valid_forward_rs2(valid_forward_rs2),
    .flush(flush), .valid_E(valid_E), .ready_E(ready_E), .pc_E(pc_E),
    .imm_E(imm_E), .type_E(type_E), .rd_E(rd_E), .ctrl_E(ctrl_E),
    .src1_E(src1_E), .src2_E(src2_E), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit          valid;
    logic [31:0] pc, imm, s1, s2;
    logic [4:0]  typ, rd;
    logic [15:0] ctrl;
  } e_slot_t;

  e_slot_t     m;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, " valid_E"},   {31'b0, valid_E}, {31'b0, m.valid});
    chk({where, " pc_E"},      pc_E,             m.pc);
    chk({where, " imm_E"},     imm_E,            m.imm);
    chk({where, " type_E"},    {27'b0, type_E},  {27'b0, m.typ});
    chk({where, " rd_E"},      {27'b0, rd_E},    {27'b0, m.rd});
    chk({where, " ctrl_E"},    {16'b0, ctrl_E},  {16'b0, m.ctrl});
    chk({where, " src1_E"},    src1_E,           m.s1);
    chk({where, " src2_E"},    src2_E,           m.s2);
    chk({where, " stall_cnt"}, stall_cnt,        m_cnt);
  endtask

  task automatic model_clear();
    m.valid = 0; m.pc = 0; m.imm = 0; m.s1 = 0; m.s2 = 0;
    m.typ = 0; m.rd = 0; m.ctrl = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic vf,
                                          input logic [31:0] fwd, input logic [31:0] rf);
    if (idx == 0) return 32'h0;
    else if (vf) return fwd;
    else return rf;
  endfunction

  // One clock: check handshake before the edge, advance model, check after the edge
  task automatic cycle(input string where);
    logic    rdy;
    e_slot_t nx;
    @(negedge clk);
    rdy = (!m.valid || ready_E) && !stall_D && !flush;
    chk({where, " ready_D"}, {31'b0, ready_D}, {31'b0, rdy});
    nx = m;
    if (flush) begin
      nx.valid = 0; nx.rd = 0;
    end else if (valid_D && rdy) begin
      nx.valid = 1; nx.pc = pc_D; nx.imm = imm_D; nx.typ = type_D;
      nx.rd = rd_D; nx.ctrl = ctrl_D;
      nx.s1 = operand(rs1_D, valid_forward_rs1, forward_rs1, rf_rdata1);
      nx.s2 = operand(rs2_D, valid_forward_rs2, forward_rs2, rf_rdata2);
    end else if (m.valid && ready_E) begin
      nx.valid = 0; nx.rd = 0;
    end
    if (valid_D && stall_D && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    @(posedge clk);
    #1;
    m = nx;
    check_all(where);
  endtask

  task automatic rand_payload();
    pc_D = {$urandom_range(0, 32'h3FFF), 2'b00};
    imm_D = $urandom; type_D = 5'($urandom); ctrl_D = 16'($urandom);
    rs1_D = 5'($urandom); rs2_D = 5'($urandom); rd_D = 5'($urandom);
    rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    forward_rs1 = $urandom; forward_rs2 = $urandom;
    valid_forward_rs1 = 1'($urandom); valid_forward_rs2 = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    valid_D = 0; stall_D = 0; flush = 0; ready_E = 0;
    rand_payload();
    model_clear();
    #2;
    check_all("reset");
    #10 rst = 1'b0;

    // Back-to-back flow
    ready_E = 1; valid_D = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_payload(); pc_D = 32'(i * 4);
      cycle("b2b");
      chk("b2b pc_E", pc_E, 32'(i * 4));
      chk("b2b valid_E", {31'b0, valid_E}, 32'd1);
    end

    // Forward select, then rs1 = x0
    rand_payload();
    rs1_D = 5; rf_rdata1 = 32'h11; forward_rs1 = 32'hAB; valid_forward_rs1 = 1;
    cycle("fwd");
    chk("fwd src1_E", src1_E, 32'hAB);
    rs1_D = 0;
    cycle("fwd_x0");
    chk("fwd_x0 src1_E", src1_E, 32'h0);

    // Load-use stall for two cycles
    rand_payload(); rd_D = 5'd9; stall_D = 1;
    cycle("stall0");
    chk("stall bubble rd_E", {27'b0, rd_E}, 32'd0);
    cycle("stall1");
    chk("stall count", stall_cnt, m_cnt);
    stall_D = 0;
    cycle("stall_launch");
    chk("stall launch rd_E", {27'b0, rd_E}, 32'd9);

    // Backpressure with changing forward data
    ready_E = 0; valid_D = 1;
    for (int i = 0; i < 3; i++) begin
      rand_payload(); valid_forward_rs2 = 1;
      cycle("bp");
    end
    chk("bp stall_cnt", stall_cnt, 32'd2);

    // Flush with valid_D and valid_E
    ready_E = 1; flush = 1; stall_D = 1;
    cycle("flush");
    chk("flush valid_E", {31'b0, valid_E}, 32'd0);
    flush = 0; stall_D = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      valid_D = ($urandom_range(0, 3) != 0);
      stall_D = ($urandom_range(0, 3) == 0);
      ready_E = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    // Async reset mid-stream, between edges
    flush = 0; stall_D = 0; ready_E = 0; valid_D = 1; rand_payload();
    cycle("pre_rst");
    #3 rst = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    #3 rst = 1'b0;
    valid_D = 0;
    cycle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_reg.md
# decode_issue_reg

Decode-to-execute pipeline register of the RV32 five-stage core. Each cycle it selects the rs1/rs2 operand from either the forwarding network or the register-file read port. It holds the decoded instruction while the RAW hazard unit asserts `stall_D`, and launches the instruction into the execute stage under a valid/ready handshake. It also discards in-flight work on a redirect flush, and counts hazard-stall cycles for performance monitoring.

## Interface
- `CTRL_W`, default 16: width of the opaque execute-control bundle (ALU op, mem size, branch kind).

Ports:
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `valid_D` in 1: decode stage holds a valid instruction.
- `ready_D` out 1: this block accepts the decode instruction this cycle.
- `pc_D` in 32: program counter of the decode instruction.
- `imm_D` in 32: decoded immediate.
- `type_D` in 5: instruction-format code, same encoding the hazard unit uses.
- `rs1_D` in 5: source register 1 index.
- `rs2_D` in 5: source register 2 index.
- `rd_D` in 5: destination register index.
- `ctrl_D` in CTRL_W: execute control bundle.
- `rf_rdata1` in 32: register-file read data for rs1.
- `rf_rdata2` in 32: register-file read data for rs2.
- `stall_D` in 1: unresolved RAW hazard from the hazard unit.
- `forward_rs1` in 32: forwarded value for rs1.
- `forward_rs2` in 32: forwarded value for rs2.
- `valid_forward_rs1` in 1: use `forward_rs1` instead of `rf_rdata1`.
- `valid_forward_rs2` in 1: use `forward_rs2` instead of `rf_rdata2`.
- `flush` in 1: redirect from execute; kill the register contents and the decode instruction.
- `valid_E` out 1: execute-stage instruction valid.
- `ready_E` in 1: execute stage consumes the instruction this cycle.
- `pc_E` out 32: registered copy of `pc_D`.
- `imm_E` out 32: registered copy of `imm_D`.
- `type_E` out 5: registered copy of `type_D`.
- `rd_E` out 5: registered copy of `rd_D`.
- `ctrl_E` out CTRL_W: registered copy of `ctrl_D`.
- `src1_E` out 32: registered rs1 operand.
- `src2_E` out 32: registered rs2 operand (store data / second ALU operand).
- `stall_cnt` out 32: count of hazard-stall cycles.

## Operation
- Operand select, combinational:
  - `op1 = (rs1_D==0) ? 0 : valid_forward_rs1 ? forward_rs1 : rf_rdata1`.
  - `op2` is the same for rs2.
- `ready_D = (~valid_E | ready_E) & ~stall_D & ~flush`.
- `fire_D = valid_D & ready_D`.
- `valid_E` next-state, in priority order:
  - `flush` → 0.
  - else `fire_D` → 1.
  - else `valid_E & ready_E` → 0 (bubble).
  - else hold.
- Payload registers:
  - On `fire_D`, the payload registers load `pc/imm/type/rd/ctrl/op1/op2`.
  - Otherwise the payload holds.
  - When `valid_E` goes 0 through flush or bubble, `rd_E` is forced to 0, so the hazard unit never matches a stale destination. The other payload fields keep their last values.
- `stall_cnt` increments when `valid_D & stall_D & ~flush`, and saturates at 0xFFFF_FFFF.
- Backpressure (`valid_E & ~ready_E`) is not counted in `stall_cnt`.
- Under backpressure, all E outputs remain stable. The operands were captured at fire time, so later forwarding changes do not alter them.
- A combinational path `ready_D ← stall_D ← valid_E/ready_E` is allowed. The upstream `valid_D` must not depend on `ready_D`.

## Timing
- Reset (async assert, sync release): `valid_E=0`; `pc_E`, `imm_E`, `type_E`, `rd_E`, `ctrl_E`, `src1_E`, `src2_E` = 0; `stall_cnt=0`.
- Latency: an instruction accepted at edge N appears on the E outputs after edge N and stays there until `ready_E` is sampled high.
- Throughput: one instruction per cycle when `stall_D=0` and `ready_E=1`.
- Simultaneous consume and accept (`valid_E & ready_E & fire_D`): the register reloads, and `valid_E` stays 1 with no bubble.
- Flush has the highest priority:
  - In the flush cycle, `ready_D=0`, so no instruction is accepted.
  - The next cycle has `valid_E=0` and `rd_E=0`.
  - Stall cycles coincident with flush are not counted.
- `stall_D` with `ready_E=1`: the E instruction drains, and the next cycle shows a bubble (`valid_E=0`, `rd_E=0`).
- Reset asserted mid-transfer clears state immediately. No instruction survives.

## Test plan
- Back-to-back flow: three instructions with PC 0x0, 0x4, 0x8, `stall_D=0`, `ready_E=1` → `pc_E` is 0x0, 0x4, 0x8 on consecutive cycles with `valid_E` continuously 1.
- Forward select: `rs1_D=5`, `rf_rdata1=0x11`, `forward_rs1=0xAB`, `valid_forward_rs1=1` → `src1_E=0xAB`. The same case with `rs1_D=0` → `src1_E=0`.
- Load-use stall: hold `stall_D=1` for 2 cycles with `valid_D=1` → `ready_D=0` for those cycles, one bubble (`valid_E=0`, `rd_E=0`), and `stall_cnt` increments by 2. The instruction launches after `stall_D` drops.
- Backpressure: `valid_E=1`, `ready_E=0` for 3 cycles while `forward_rs2` changes → the E outputs are constant, `ready_D=0`, and `stall_cnt` is unchanged.
- Flush during a valid transfer: `flush=1` with `valid_D=1` and `valid_E=1` → the next cycle has `valid_E=0` and `rd_E=0`, and the decode instruction is not accepted.
- Async reset asserted mid-stream, between clock edges → all outputs go to 0 immediately, and `stall_cnt=0`.
